ahb_bram_bridge: RTL and testbench
==================================

Name: ahb_bram_bridge

Overview:
AHB-Lite slave that converts bus transfers into single-port block-RAM accesses. It sits directly upstream of the program/data block RAM, which has a 1-cycle registered read and byte write enables. It drives that RAM's address, write data and byte-enable inputs and returns its registered read data to the bus. Zero-wait reads and writes, with one wait state only for a read immediately following a write. Two-cycle ERROR response for illegal size or alignment.

Parameters:
ADDR_WIDTH, 14, word-address width of the attached RAM; bytes decoded = 4*2**ADDR_WIDTH.

Ports:
HCLK  in  1  system clock; also clocks the RAM
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slave select
HADDR  in  32  byte address (address phase)
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
HWRITE  in  1  1=write
HSIZE  in  3  0=byte, 1=half, 2=word; others illegal
HREADY  in  1  bus-wide ready
HWDATA  in  32  write data (data phase)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data (= BRAM_RDATA, combinational)
BRAM_ADDR  out  ADDR_WIDTH  RAM word address
BRAM_WDATA  out  32  RAM write data (= HWDATA)
BRAM_WE  out  4  RAM byte write enables
BRAM_RDATA  in  32  RAM registered read data

Behaviour:
- Reset: asynchronous, active-high. Forces state to IDLE and all captured registers to 0. Outputs while reset is asserted: HREADYOUT=1, HRESP=0, BRAM_WE=0. Reset mid-transfer aborts the transfer; no partial write occurs after reset is asserted.
- Accept condition: HSEL & HREADY & HTRANS[1], sampled at the rising edge of HCLK. Word address = HADDR[ADDR_WIDTH+1:2]; upper bits are ignored (aliasing).
- Legal transfer:
  - HSIZE=0: any alignment.
  - HSIZE=1: HADDR[0]=0.
  - HSIZE=2: HADDR[1:0]=0.
  - Any other size or alignment is illegal.
- Byte mask:
  - byte: 4'b0001<<HADDR[1:0]
  - half: 4'b0011<<{HADDR[1],1'b0}
  - word: 4'b1111
- On accept, capture: word address, mask, write flag, legal flag.
- States:
  - IDLE: no data phase pending.
  - WDATA: write data phase.
  - RDATA: read data phase.
  - RSTALL: read data phase, wait cycle.
  - ERR1, ERR2: two-cycle ERROR response.
- Transitions from an accept (taken from IDLE, WDATA, RDATA or ERR2 when the next transfer is accepted):
  - illegal transfer → ERR1.
  - legal write → WDATA.
  - legal read while the current state is WDATA → RSTALL.
  - legal read otherwise → RDATA.
- Transitions without an accept:
  - from IDLE/WDATA/RDATA/ERR2 → IDLE.
  - RSTALL → RDATA (fixed).
  - ERR1 → ERR2 (fixed).
- BRAM_ADDR selection:
  - WDATA or RSTALL: captured address.
  - otherwise: HADDR word address (read issued in the address phase).
- BRAM_WE = captured mask in WDATA only, else 0. The write commits at the end of the single WDATA cycle. BRAM_WDATA = HWDATA always.
- Output values per state:
  - IDLE, WDATA, RDATA: HREADYOUT=1, HRESP=0.
  - RSTALL: HREADYOUT=0, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Latency:
  - Normal read: 0 wait states; RAM samples in the address phase and HRDATA is valid in the data phase.
  - Write followed immediately by read: 1 wait state. RAM samples the read address during RSTALL, after the write has committed, so same-address read-after-write returns the new data.
- HRDATA is meaningful only in the final RDATA cycle. Its value in other states is don't-care.
- Illegal transfers never assert BRAM_WE.
- IDLE/BUSY transfers and HSEL=0 get an OKAY zero-wait response with no write. Background RAM reads are harmless.
- An address phase presented while HREADY=0 is ignored and is not captured.

Test Plan:
- Reset → HREADYOUT=1, HRESP=0, BRAM_WE=0. Word write 0x12345678 to 0x10, then read 0x10 with one idle cycle between → HRDATA=0x12345678, no wait states.
- Byte writes 0xAA to 0x21, then half-word write 0xBEEF to 0x22, over an existing word 0x00000000 at 0x20 → BRAM_WE=0010 then 1100; a read returns 0xBEEFAA00.
- Back-to-back write 0xCAFEF00D to 0x40 followed by read of 0x40 → exactly one HREADYOUT=0 cycle, then HRDATA=0xCAFEF00D.
- Back-to-back reads of 0x0,0x4,0x8 preloaded with 1,2,3 → data 1,2,3 on consecutive cycles, HREADYOUT constantly 1.
- Word write to 0x42 (misaligned) and HSIZE=3 → HRESP=1 with HREADYOUT 0 then 1; BRAM_WE stays 0; memory is unchanged.
- HRESET asserted during a WDATA cycle → BRAM_WE drops to 0 immediately, the target word is unchanged, and HREADYOUT=1.

Source files
------------

// File: rtl/ahb_bram_bridge_if.sv
// AHB-Lite slave bus plus block-RAM port bundle for ahb_bram_bridge.
// slave: bridge view; master: bus master and RAM side together.
interface ahb_bram_bridge_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic                  HREADY;
  logic [31:0]           HWDATA;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic [ADDR_WIDTH-1:0] BRAM_ADDR;
  logic [31:0]           BRAM_WDATA;
  logic [3:0]            BRAM_WE;
  logic [31:0]           BRAM_RDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, BRAM_RDATA,
    output HREADYOUT, HRESP, HRDATA, BRAM_ADDR, BRAM_WDATA, BRAM_WE
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, BRAM_RDATA,
    input  HREADYOUT, HRESP, HRDATA, BRAM_ADDR, BRAM_WDATA, BRAM_WE
  );
endinterface

// File: rtl/ahb_bram_bridge.sv
// AHB-Lite slave driving a single-port block RAM with 1-cycle registered read.
// Zero-wait reads/writes; one wait for read-after-write; two-cycle ERROR.
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 14
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb_bram_bridge_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WDATA, RDATA, RSTALL, ERR1, ERR2} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, haddr_word;
  logic [3:0]            mask_q, mask_d;
  logic                  write_q, legal_q;
  logic                  legal_d, open_phase, accept;

  always_comb haddr_word = bus.HADDR[ADDR_WIDTH+1:2];

  always_comb begin
    legal_d = 1'b0;
    mask_d  = '0;
    case (bus.HSIZE)
      3'd0: begin
        legal_d = 1'b1;
        mask_d  = 4'b0001 << bus.HADDR[1:0];
      end
      3'd1: begin
        legal_d = ~bus.HADDR[0];
        mask_d  = 4'b0011 << {bus.HADDR[1], 1'b0};
      end
      3'd2: begin
        legal_d = (bus.HADDR[1:0] == 2'b00);
        mask_d  = '1;
      end
      default: ;
    endcase
  end

  // A new address phase can only land in a cycle where we drive HREADYOUT=1.
  always_comb begin
    open_phase = (state == IDLE) || (state == WDATA) ||
                 (state == RDATA) || (state == ERR2);
    accept     = open_phase & bus.HSEL & bus.HREADY & bus.HTRANS[1];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      legal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= haddr_word;
        mask_q  <= mask_d;
        write_q <= bus.HWRITE;
        legal_q <= legal_d;
      end
    end
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      RSTALL: state_nx = RDATA;
      ERR1:   state_nx = ERR2;
      default: begin
        if (accept) begin
          if (!legal_d)           state_nx = ERR1;
          else if (bus.HWRITE)    state_nx = WDATA;
          else if (state == WDATA) state_nx = RSTALL;
          else                    state_nx = RDATA;
        end
      end
    endcase
  end

  // Reads are issued from HADDR in the address phase; RSTALL re-issues the
  // captured read address once the preceding write has committed.
  always_comb begin
    bus.HREADYOUT  = 1'b1;
    bus.HRESP      = 1'b0;
    bus.BRAM_ADDR  = haddr_word;
    bus.BRAM_WE    = '0;
    bus.BRAM_WDATA = bus.HWDATA;
    bus.HRDATA     = bus.BRAM_RDATA;
    case (state)
      WDATA: begin
        bus.BRAM_ADDR = addr_q;
        bus.BRAM_WE   = (write_q && legal_q) ? mask_q : '0;
      end
      RSTALL: begin
        bus.BRAM_ADDR = addr_q;
        bus.HREADYOUT = 1'b0;
      end
      ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
      end
      ERR2: bus.HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// Scoreboard bench for ahb_bram_bridge: driver predicts responses from a
// word-array memory model, monitor checks every data-phase cycle.
module tb_ahb_bram_bridge;

  localparam int AW = 8;
  localparam int NW = 1 << AW;

  logic HCLK = 1'b0;
  logic HRESET;
  logic hready_gate;

  ahb_bram_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  assign bus.HREADY = bus.HREADYOUT & hready_gate;

  // Block RAM: byte write enables, registered read-first output.
  logic [31:0] ram [NW];
  logic [31:0] ram_q;
  always @(posedge HCLK) begin
    for (int b = 0; b < 4; b++)
      if (bus.BRAM_WE[b]) ram[bus.BRAM_ADDR][b*8 +: 8] <= bus.BRAM_WDATA[b*8 +: 8];
    ram_q <= ram[bus.BRAM_ADDR];
  end
  assign bus.BRAM_RDATA = ram_q;

  typedef struct {
    logic        wr;
    logic        legal;
    logic [3:0]  mask;
    logic [31:0] data;
    int unsigned waits;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] refmem [NW];
  int          checks   = 0;
  int          failures = 0;
  logic        prev_lw  = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic is_legal(logic [2:0] sz, logic [31:0] a);
    case (sz)
      3'd0:    return 1'b1;
      3'd1:    return a[0] == 1'b0;
      3'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Bytes touched: 2**size consecutive lanes starting at the byte offset.
  function automatic logic [3:0] lanes(logic [2:0] sz, logic [31:0] a);
    int unsigned n, m;
    n = 1 << sz;
    m = ((1 << n) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic int unsigned widx(logic [31:0] a);
    return (a >> 2) % NW;
  endfunction

  task automatic put_ap(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                        input logic commit);
    logic        rdy, acc, lg;
    exp_t        e;
    int unsigned n;
    bus.HSEL   = sel;
    bus.HTRANS = tr;
    bus.HADDR  = a;
    bus.HSIZE  = sz;
    bus.HWRITE = wr;
    n = 0;
    forever begin
      @(negedge HCLK);
      rdy = bus.HREADY;
      acc = rdy & sel & tr[1];
      lg  = is_legal(sz, a);
      if (acc && commit) begin
        e.wr    = wr;
        e.legal = lg;
        e.mask  = lg ? lanes(sz, a) : 4'b0000;
        e.data  = refmem[widx(a)];
        e.waits = !lg ? 1 : ((!wr && prev_lw) ? 1 : 0);
        if (lg && wr)
          for (int b = 0; b < 4; b++)
            if (e.mask[b]) refmem[widx(a)][b*8 +: 8] = wd[b*8 +: 8];
        sbq.push_back(e);
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        prev_lw    = acc & lg & wr;
        bus.HWDATA = (acc && wr) ? wd : $urandom;
        return;
      end
      n++;
      if (n > 8) begin
        chk("addr_phase_stall_timeout", 32'(n), 32'd0);
        return;
      end
    end
  endtask

  task automatic idle();
    put_ap(1'b0, 2'b00, $urandom, 3'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic wr_t(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    put_ap(1'b1, 2'b10, a, sz, 1'b1, wd, 1'b1);
  endtask

  task automatic rd_t(input logic [31:0] a);
    put_ap(1'b1, 2'b10, a, 3'd2, 1'b0, 32'd0, 1'b1);
  endtask

  // Monitor: tracks the data phase from the bus and pops one expectation per transfer.
  initial begin
    logic        dp, have;
    exp_t        cur;
    int unsigned w;
    dp = 1'b0; have = 1'b0; w = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dp = 1'b0; have = 1'b0; w = 0;
        continue;
      end
      if (dp) begin
        if (!have) begin
          if (sbq.size() == 0) begin
            chk("scoreboard_underflow", 32'd0, 32'd1);
            dp = 1'b0;
          end else begin
            cur  = sbq.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("hresp", 32'(bus.HRESP), 32'(!cur.legal));
          chk("bram_we", 32'(bus.BRAM_WE),
              (bus.HREADYOUT && cur.wr && cur.legal) ? 32'(cur.mask) : 32'd0);
          if (!bus.HREADYOUT) begin
            w++;
            if (w > 4) begin
              chk("data_phase_timeout", w, cur.waits);
              have = 1'b0; w = 0; dp = 1'b0;
            end
          end else begin
            chk("wait_states", w, cur.waits);
            if (!cur.wr && cur.legal) chk("hrdata", bus.HRDATA, cur.data);
            have = 1'b0; w = 0;
          end
        end
      end else begin
        chk("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("idle_hresp", 32'(bus.HRESP), 32'd0);
        chk("idle_bram_we", 32'(bus.BRAM_WE), 32'd0);
      end
      if (bus.HREADY) dp = bus.HSEL & bus.HTRANS[1];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, v;
    logic [2:0]  sz;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HSIZE = 3'd0;
    bus.HWRITE = 1'b0; bus.HWDATA = '0;
    hready_gate = 1'b1;
    HRESET = 1'b1;
    for (int i = 0; i < NW; i++) begin
      v = $urandom;
      ram[i] = v;
      refmem[i] = v;
    end
    repeat (2) @(negedge HCLK);
    chk("reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("reset_hresp", 32'(bus.HRESP), 32'd0);
    chk("reset_bram_we", 32'(bus.BRAM_WE), 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    idle();

    // Word write, one idle, read back
    wr_t(32'h10, 3'd2, 32'h1234_5678); idle(); rd_t(32'h10); idle();

    // Byte then half-word over a zero word
    ram[8] = 32'd0; refmem[8] = 32'd0;
    wr_t(32'h21, 3'd0, 32'h0000_AA00); wr_t(32'h22, 3'd1, 32'hBEEF_0000); idle();
    rd_t(32'h20); idle();

    // Write immediately followed by read of the same word
    wr_t(32'h40, 3'd2, 32'hCAFE_F00D); rd_t(32'h40); idle();

    // Back-to-back reads
    for (int i = 0; i < 3; i++) begin
      ram[i] = 32'(i + 1);
      refmem[i] = 32'(i + 1);
    end
    rd_t(32'h0); rd_t(32'h4); rd_t(32'h8); idle();

    // Illegal: misaligned word, size 3
    wr_t(32'h42, 3'd2, 32'h1111_1111); wr_t(32'h44, 3'd3, 32'h2222_2222); idle();
    rd_t(32'h40); rd_t(32'h44); idle();

    // Address phase with HREADY low must be ignored
    hready_gate = 1'b0;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h84; bus.HSIZE = 3'd2;
    bus.HWRITE = 1'b1;
    @(posedge HCLK); #1;
    hready_gate = 1'b1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'hDEAD_BEEF;
    chk("gated_no_write", 32'(bus.BRAM_WE), 32'd0);
    idle(); rd_t(32'h84); idle();

    // Reset during the write data phase
    put_ap(1'b1, 2'b10, 32'h88, 3'd2, 1'b1, 32'h5A5A_5A5A, 1'b0);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    #2 HRESET = 1'b1;
    #1;
    chk("rst_mid_we", 32'(bus.BRAM_WE), 32'd0);
    chk("rst_mid_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    idle(); rd_t(32'h88); idle();

    // Randomized traffic concentrated on 16 words with aliased upper bits
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      put_ap($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), a, sz,
             1'($urandom_range(0, 1)), $urandom, 1'b1);
    end
    repeat (3) idle();

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < NW; i++) chk("final_memory", ram[i], refmem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
